// File: rtl/mem_access_fsm_pkg.sv
// Shared types and helpers for the byte-serial load/store unit: op codes,
// FSM states, per-op byte count and load extension.
package mem_access_fsm_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic [2:0] op_bytes(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
      OP_LW, OP_SW:         op_bytes = 3'd4;
      default:              op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic is_load(input mem_op_e op);
    is_load = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    is_store = op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Works at 64 bits; callers truncate, so LW only sign-extends when XLEN > 32.
  function automatic logic [63:0] load_ext64(input mem_op_e op, input logic [63:0] v);
    case (op)
      OP_LB:   load_ext64 = {{56{v[7]}}, v[7:0]};
      OP_LBU:  load_ext64 = {56'd0, v[7:0]};
      OP_LH:   load_ext64 = {{48{v[15]}}, v[15:0]};
      OP_LHU:  load_ext64 = {48'd0, v[15:0]};
      OP_LW:   load_ext64 = {{32{v[31]}}, v[31:0]};
      default: load_ext64 = v;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational sign/zero extension of the assembled load bytes.
module mem_load_ext
  import mem_access_fsm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_op_e           op,
  input  logic [XLEN-1:0]   raw,
  output logic [XLEN-1:0]   ext
);

  assign ext = XLEN'(load_ext64(op, 64'(raw)));

endmodule

// File: rtl/mem_access_fsm.sv
// Byte-serial memory access stage: splits LB/LH/LW/SB/SH/SW into byte RAM
// handshakes and stalls upstream meanwhile. Optional MEM_ALIGN_CHECK_EN rejects misaligned ops.
//
// RAM handshake: ram_req_o and its address/data/we are held stable until the
// cycle ram_ack_i is high; that cycle completes the byte (ram_rdata_i valid).
module mem_access_fsm
  import mem_access_fsm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 17,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic              ram_ack_i,
  input  logic [7:0]        ram_rdata_i,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              stall_req_o,
  output logic              misalign_o,
  output state_e            dbg_state_o
);

  state_e            state_q;
  mem_op_e           op_q;
  logic [2:0]        cnt_q;
  logic [XLEN-1:0]   asm_q;
  logic [XLEN-1:0]   sdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [REG_AW-1:0] wd_q;
  logic              wreg_q;
  logic              ram_req_q;
  logic              ram_we_q;

  mem_op_e         op_in;
  logic            is_mem_in;
  logic            misalign_in;
  logic            start;
  logic [2:0]      cnt_nxt;
  logic            last_byte;
  logic [XLEN-1:0] ext_data;

  assign op_in     = mem_op_e'(mem_op_i);
  assign is_mem_in = is_load(op_in) | is_store(op_in);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_in = ((op_in inside {OP_LH, OP_LHU, OP_SH}) && mem_addr_i[0]) ||
                       ((op_in inside {OP_LW, OP_SW}) && (mem_addr_i[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  assign start     = (state_q == ST_IDLE) && valid_i && is_mem_in && !misalign_in;
  assign cnt_nxt   = cnt_q + 3'd1;
  assign last_byte = (cnt_q == op_bytes(op_q) - 3'd1);

  mem_load_ext #(.XLEN(XLEN)) u_ext (
    .op  (op_q),
    .raw (asm_q),
    .ext (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      cnt_q       <= 3'd0;
      asm_q       <= '0;
      sdata_q     <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q        <= op_in;
            addr_q      <= mem_addr_i;
            sdata_q     <= mem_wdata_i;
            wd_q        <= wd_i;
            wreg_q      <= wreg_i;
            cnt_q       <= 3'd0;
            asm_q       <= '0;
            ram_req_q   <= 1'b1;
            ram_we_q    <= is_store(op_in);
            ram_addr_o  <= mem_addr_i;
            ram_wdata_o <= mem_wdata_i[7:0];
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (ram_ack_i) begin
            // asm_q was cleared at issue, so OR-ing each byte into place assembles it.
            if (is_load(op_q))
              asm_q <= asm_q | (XLEN'(ram_rdata_i) << {cnt_q, 3'b000});
            cnt_q <= cnt_nxt;
            if (last_byte) begin
              ram_req_q <= 1'b0;
              ram_we_q  <= 1'b0;
              state_q   <= ST_DONE;
            end else begin
              ram_addr_o  <= addr_q + ADDR_W'(cnt_nxt);
              ram_wdata_o <= 8'(sdata_q >> {cnt_nxt, 3'b000});
            end
          end
        end
        ST_DONE: begin
          cnt_q   <= 3'd0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Writeback and stall are combinational so IDLE pass-through has zero latency.
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i && is_mem_in) begin
            misalign_o  = misalign_in;
            stall_req_o = !misalign_in;
          end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        ST_ACCESS: stall_req_o = 1'b1;
        ST_DONE: begin
          if (is_load(op_q)) begin
            wd_o    = wd_q;
            wreg_o  = wreg_q;
            wdata_o = ext_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_req_o   = ram_req_q & ~rst;
  assign ram_we_o    = ram_we_q & ~rst;
  assign dbg_state_o = state_q;

endmodule
